// File: rtl/wave_frame_streamer_if.sv
// Output sample stream of the wave frame streamer: valid/ready beats with frame/line markers.
interface wave_frame_streamer_if #(
  parameter int unsigned MAG_W = 16
) ();
  logic             m_valid;
  logic             m_ready;
  logic [MAG_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (
    output m_valid,
    output m_data,
    output m_sof,
    output m_eol,
    output m_eof,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_sof,
    input  m_eol,
    input  m_eof,
    output m_ready
  );
endinterface

// File: rtl/wave_frame_streamer.sv
// Raster-scans the wave mesh read port on every accepted frame_done and streams
// |Psi|^2 samples out with sof/eol/eof markers; counts delivered and dropped frames.
// MAG_W must equal the mesh PSI_WIDTH.
module wave_frame_streamer #(
  parameter int unsigned MESH_X = 8,
  parameter int unsigned MESH_Y = 8,
  parameter int unsigned MAG_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stream_en_i,
  input  logic                      frame_done_i,
  output logic [$clog2(MESH_X)-1:0] read_x_o,
  output logic [$clog2(MESH_Y)-1:0] read_y_o,
  input  logic [MAG_W-1:0]          read_magnitude_i,
  wave_frame_streamer_if.master     m_if,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          frame_count_o,
  output logic [CNT_W-1:0]          overrun_count_o,
  output logic                      overrun_o,
  input  logic                      overrun_clr_i
);

  localparam int unsigned X_W = $clog2(MESH_X);
  localparam int unsigned Y_W = $clog2(MESH_Y);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             m_valid_q, m_valid_d;
  logic [MAG_W-1:0] m_data_q, m_data_d;
  logic             m_sof_q, m_sof_d;
  logic             m_eol_q, m_eol_d;
  logic             m_eof_q, m_eof_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             ovr_q, ovr_d;

  logic handshake;
  logic start_req;
  logic load;
  logic x_last;
  logic y_last;

  assign handshake = m_valid_q && m_if.m_ready;
  assign start_req = frame_done_i && stream_en_i;
  assign load      = !m_valid_q || m_if.m_ready;
  assign x_last    = (x_q == X_W'(MESH_X - 1));
  assign y_last    = (y_q == Y_W'(MESH_Y - 1));

  // State, address, output beat and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_sof_q     <= 1'b0;
      m_eol_q     <= 1'b0;
      m_eof_q     <= 1'b0;
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_sof_q     <= m_sof_d;
      m_eol_q     <= m_eol_d;
      m_eof_q     <= m_eof_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  // Next-state: scan sequencing, beat loading, frame and overrun bookkeeping.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_sof_d     = m_sof_q;
    m_eol_d     = m_eol_q;
    m_eof_d     = m_eof_q;
    frame_cnt_d = frame_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    ovr_d       = ovr_q;

    if (handshake && m_eof_q) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if (overrun_clr_i) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Drain the last beat; a still-pending beat does not block a new frame.
        if (handshake) begin
          m_valid_d = 1'b0;
          m_sof_d   = 1'b0;
          m_eol_d   = 1'b0;
          m_eof_d   = 1'b0;
        end
        if (start_req) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        // A frame arriving mid-scan is dropped; setting wins over clearing.
        if (start_req) begin
          ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
          ovr_d     = 1'b1;
        end
        if (load) begin
          m_data_d  = read_magnitude_i;
          m_sof_d   = (x_q == '0) && (y_q == '0);
          m_eol_d   = x_last;
          m_eof_d   = x_last && y_last;
          m_valid_d = 1'b1;
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d     = '0;
              state_d = IDLE;
            end else begin
              y_d = y_q + Y_W'(1);
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_x_o        = x_q;
  assign read_y_o        = y_q;
  assign m_if.m_valid    = m_valid_q;
  assign m_if.m_data     = m_data_q;
  assign m_if.m_sof      = m_sof_q;
  assign m_if.m_eol      = m_eol_q;
  assign m_if.m_eof      = m_eof_q;
  assign busy_o          = (state_q == SCAN);
  assign frame_count_o   = frame_cnt_q;
  assign overrun_count_o = ovr_cnt_q;
  assign overrun_o       = ovr_q;

endmodule

// File: tb/tb_wave_frame_streamer.sv
// Bench for wave_frame_streamer on a 4x4 mesh: directed scenarios plus random traffic,
// checked every cycle against a site-index reference model and a beat-order scoreboard.
module tb_wave_frame_streamer;

  localparam int MX = 4;
  localparam int MY = 4;
  localparam int NS = MX * MY;
  localparam int MW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, fd, rdy, clr;
  logic [1:0]    read_x, read_y;
  logic [MW-1:0] read_mag;
  logic          busy, ovr;
  logic [CW-1:0] fcnt, ocnt;
  int            mesh_base;
  int            cyc;

  wave_frame_streamer_if #(.MAG_W(MW)) s_if ();

  wave_frame_streamer #(.MESH_X(MX), .MESH_Y(MY), .MAG_W(MW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .stream_en_i      (en),
    .frame_done_i     (fd),
    .read_x_o         (read_x),
    .read_y_o         (read_y),
    .read_magnitude_i (read_mag),
    .m_if             (s_if.master),
    .busy_o           (busy),
    .frame_count_o    (fcnt),
    .overrun_count_o  (ocnt),
    .overrun_o        (ovr),
    .overrun_clr_i    (clr)
  );

  always #5 clk = ~clk;

  function automatic int mesh(int x, int y);
    return (mesh_base + 10 * y + x) & 16'hFFFF;
  endfunction

  assign s_if.m_ready = rdy;
  assign read_mag     = MW'(mesh(int'(read_x), int'(read_y)));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  initial cyc = 0;

  // Reference model: a frame is a sequence of site indices 0..NS-1 loaded whenever the
  // output slot is free or being taken.
  bit mv, ms, ml, me, m_scan, m_ov;
  int md, m_site, m_fc, m_oc;

  always @(posedge clk or posedge rst) begin
    bit hs, st;
    int x, y;
    if (rst) begin
      mv = 0; ms = 0; ml = 0; me = 0; md = 0;
      m_scan = 0; m_site = 0; m_fc = 0; m_oc = 0; m_ov = 0;
    end else begin
      hs = mv && rdy;
      st = fd && en;
      if (hs && me) m_fc = (m_fc + 1) % 65536;
      if (clr) m_ov = 0;
      if (m_scan && st) begin
        m_ov = 1;
        m_oc = (m_oc + 1) % 65536;
      end
      if (!m_scan) begin
        if (hs) begin mv = 0; ms = 0; ml = 0; me = 0; end
        if (st) begin m_scan = 1; m_site = 0; end
      end else if (!mv || rdy) begin
        x  = m_site % MX;
        y  = m_site / MX;
        md = mesh(x, y);
        ms = (m_site == 0);
        ml = (x == MX - 1);
        me = (m_site == NS - 1);
        mv = 1;
        m_site++;
        if (m_site == NS) begin m_scan = 0; m_site = 0; end
      end
    end
  end

  typedef struct { int cyc; int data; bit sof; bit eol; bit eof; } beat_t;
  beat_t log_q[$];
  int    bidx;
  bit    prev_stall;
  int    prev_data;

  // Compare process: DUT vs model each cycle, plus beat ordering and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      bidx = 0;
      prev_stall = 0;
    end else begin
      chk("m_valid", int'(s_if.m_valid), int'(mv));
      chk("busy", int'(busy), int'(m_scan));
      chk("frame_count", int'(fcnt), m_fc);
      chk("overrun_count", int'(ocnt), m_oc);
      chk("overrun", int'(ovr), int'(m_ov));
      if (mv) begin
        chk("m_data", int'(s_if.m_data), md);
        chk("m_sof", int'(s_if.m_sof), int'(ms));
        chk("m_eol", int'(s_if.m_eol), int'(ml));
        chk("m_eof", int'(s_if.m_eof), int'(me));
      end else begin
        chk("markers_idle", int'({s_if.m_sof, s_if.m_eol, s_if.m_eof}), 0);
      end
      if (prev_stall) chk("stall_hold", int'(s_if.m_data), prev_data);
      if (s_if.m_valid && rdy) begin
        chk("order_sof", int'(s_if.m_sof), int'(bidx == 0));
        chk("order_eol", int'(s_if.m_eol), int'(bidx % MX == MX - 1));
        chk("order_eof", int'(s_if.m_eof), int'(bidx == NS - 1));
        bidx = (bidx + 1) % NS;
        log_q.push_back('{cyc, int'(s_if.m_data), s_if.m_sof, s_if.m_eol, s_if.m_eof});
      end
      prev_stall = s_if.m_valid && !rdy;
      prev_data  = int'(s_if.m_data);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_fd();
    fd = 1'b1;
    step();
    fd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; fd = 1'b0; clr = 1'b0; en = 1'b1; rdy = 1'b1; mesh_base = 0;
    step(2);
    rst = 1'b0;
    log_q.delete();
    step();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (log_q.size() < n) chk("timeout_beats", log_q.size(), n);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; fd = 1'b0; rdy = 1'b1; clr = 1'b0; mesh_base = 0;
    step(2);
    rst = 1'b0;
    chk("reset_valid", int'(s_if.m_valid), 0);
    chk("reset_counts", int'(fcnt) + int'(ocnt), 0);
    chk("reset_addr", int'({read_x, read_y}), 0);

    // 1: baseline timing with ready held high
    while (cyc < 10) step();
    pulse_fd();
    while (cyc < 27) step();
    chk("t1_busy_low_27", int'(busy), 0);
    chk("t1_eof_at_27", int'(s_if.m_valid && s_if.m_eof), 1);
    step(5);
    chk("t1_beats", log_q.size(), 16);
    if (log_q.size() == 16) begin
      chk("t1_first_cyc", log_q[0].cyc, 12);
      chk("t1_first_data", log_q[0].data, 0);
      chk("t1_first_sof", int'(log_q[0].sof), 1);
      chk("t1_eol3", int'(log_q[3].eol), 1);
      chk("t1_data4", log_q[4].data, 10);
      chk("t1_last_data", log_q[15].data, 33);
      chk("t1_last_cyc", log_q[15].cyc, 27);
      chk("t1_last_eof", int'(log_q[15].eof), 1);
    end
    chk("t1_frame_count", int'(fcnt), 1);

    // 2: alternating backpressure
    do_reset();
    pulse_fd();
    for (int i = 0; i < 80; i++) begin
      rdy = cyc[0];
      step();
    end
    rdy = 1'b1;
    step(2);
    chk("t2_beats", log_q.size(), 16);
    for (int i = 0; i < log_q.size() && i < 16; i++)
      chk("t2_data", log_q[i].data, 10 * (i / MX) + i % MX);
    chk("t2_frame_count", int'(fcnt), 1);

    // 3: overrun and its clear
    do_reset();
    pulse_fd();
    step(4);
    pulse_fd();
    step(30);
    chk("t3_overrun", int'(ovr), 1);
    chk("t3_overrun_count", int'(ocnt), 1);
    chk("t3_beats", log_q.size(), 16);
    pulse_fd();
    step(30);
    chk("t3_beats2", log_q.size(), 32);
    chk("t3_frame_count", int'(fcnt), 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_cleared", int'(ovr), 0);
    chk("t3_count_kept", int'(ocnt), 1);

    // 4: stream_en gating
    do_reset();
    en = 1'b0;
    pulse_fd();
    step(30);
    chk("t4_no_beats", log_q.size(), 0);
    chk("t4_counts", int'(fcnt) + int'(ocnt), 0);
    en = 1'b1;
    pulse_fd();
    wait_log(5, 40);
    en = 1'b0;
    pulse_fd();
    step(30);
    chk("t4_full_frame", log_q.size(), 16);
    chk("t4_no_overrun", int'(ocnt), 0);
    chk("t4_frame_count", int'(fcnt), 1);
    en = 1'b1;

    // 5: reset in mid-frame
    do_reset();
    pulse_fd();
    wait_log(16, 40);
    step(3);
    pulse_fd();
    wait_log(23, 40);
    chk("t5_pre_count", int'(fcnt), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", int'(s_if.m_valid), 0);
    chk("t5_rst_fcnt", int'(fcnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    log_q.delete();
    step();
    pulse_fd();
    step(30);
    chk("t5_beats", log_q.size(), 16);
    if (log_q.size() > 0) begin
      chk("t5_sof", int'(log_q[0].sof), 1);
      chk("t5_data0", log_q[0].data, 0);
    end

    // 6: new frame while the eof beat is still pending
    do_reset();
    pulse_fd();
    begin
      int k;
      k = 0;
      while (!(s_if.m_valid && s_if.m_eof) && k < 40) begin
        step();
        k++;
      end
      if (k == 40) chk("timeout_eof", 0, 1);
    end
    rdy = 1'b0;
    step();
    pulse_fd();
    step(3);
    rdy = 1'b1;
    step(30);
    chk("t6_beats", log_q.size(), 32);
    if (log_q.size() == 32) begin
      chk("t6_eof_first", int'(log_q[15].eof), 1);
      chk("t6_sof_next", int'(log_q[16].sof), 1);
      chk("t6_data_next", log_q[16].data, 0);
    end
    chk("t6_no_overrun", int'(ocnt), 0);
    chk("t6_frame_count", int'(fcnt), 2);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rdy = ($urandom_range(9) < 7);
      fd  = ($urandom_range(39) == 0);
      clr = ($urandom_range(99) == 0);
      if ($urandom_range(199) == 0) en = ~en;
      if (fd) mesh_base = int'($urandom_range(999));
      step();
    end
    fd = 1'b0; clr = 1'b0; rdy = 1'b1;
    step(40);
    chk("rand_drained", int'(s_if.m_valid || busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
